// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI target.
package spi_pkg;

  // {CPOL, CPHA}; mode 0 idles sck low and samples on the rising edge.
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with rise/fall pulses taken against a one-cycle-delayed copy.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled pins, byte-wide rx valid/ready port, one-entry tx buffer.
module spi_target
  import spi_pkg::*;
#(
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] DEFAULT_TX = 8'hFF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              sck_i,
  input  logic              csn_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [BYTE_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [BYTE_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              frame_start_o,
  output logic              frame_end_o,
  output logic              overrun_o,
  output logic              underrun_o,
  output logic              abort_o,
  input  logic              err_clr_i
);

  logic sck_q, sck_rise, sck_fall;
  logic csn_q, csn_rise, csn_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (SPI_MODE0[1])
  ) u_sync_sck (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (sck_i),
    .q_o    (sck_q),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_sync_csn (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (csn_i),
    .q_o    (csn_q),
    .rise_o (csn_rise),
    .fall_o (csn_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sync_mosi (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (mosi_i),
    .q_o    (mosi_q),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_q, csn_q, mosi_rise, mosi_fall};

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-2:0] rx_shift_q, rx_shift_d;
  logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;
  logic [BYTE_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_end_q, frame_end_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;
  logic              abort_q, abort_d;

  logic load, byte_done, abort_set, underrun_set, overrun_set, tx_hs;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    load          = 1'b0;
    byte_done     = 1'b0;
    abort_set     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (csn_fall) begin
          state_d       = ST_ACTIVE;
          bit_cnt_d     = '0;
          frame_start_d = 1'b1;
          load          = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // csn rising takes priority over a coincident sck edge.
        if (csn_rise) begin
          state_d     = ST_IDLE;
          frame_end_d = 1'b1;
          abort_set   = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[BYTE_W-3:0], mosi_q};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          byte_done  = (bit_cnt_q == 3'd7);
        end else if (sck_fall) begin
          if (bit_cnt_q != '0) tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
          else                 load       = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) tx_shift_d = buf_full_q ? buf_q : DEFAULT_TX;
  end

  // A handshake in a load cycle only fills the buffer; the shift register already took DEFAULT_TX.
  always_comb begin
    tx_hs        = tx_valid_i & ~buf_full_q;
    underrun_set = load & ~buf_full_q;
    buf_d        = buf_q;
    buf_full_d   = buf_full_q;
    if (load && buf_full_q) buf_full_d = 1'b0;
    if (tx_hs) begin
      buf_d      = tx_data_i;
      buf_full_d = 1'b1;
    end
  end

  always_comb begin
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    overrun_set = 1'b0;
    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
    if (byte_done) begin
      rx_valid_d  = 1'b1;
      rx_data_d   = {rx_shift_q, mosi_q};
      overrun_set = rx_valid_q & ~rx_ready_i;
    end
  end

  always_comb begin
    overrun_d  = (err_clr_i ? 1'b0 : overrun_q)  | overrun_set;
    underrun_d = (err_clr_i ? 1'b0 : underrun_q) | underrun_set;
    abort_d    = (err_clr_i ? 1'b0 : abort_q)    | abort_set;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      overrun_q     <= 1'b0;
      underrun_q    <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      overrun_q     <= overrun_d;
      underrun_q    <= underrun_d;
      abort_q       <= abort_d;
    end
  end

  assign miso_oe_o     = (state_q == ST_ACTIVE);
  assign miso_o        = (state_q == ST_ACTIVE) & tx_shift_q[BYTE_W-1];
  assign tx_ready_o    = ~buf_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign frame_start_o = frame_start_q;
  assign frame_end_o   = frame_end_q;
  assign overrun_o     = overrun_q;
  assign underrun_o    = underrun_q;
  assign abort_o       = abort_q;

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: queued expected miso/rx bytes checked as the DUT produces them.
module tb_spi_target;

  localparam int H = 8;  // sck half-period in clk cycles

  logic       clk = 1'b0;
  logic       rstn;
  logic       sck, csn, mosi;
  logic       miso, miso_oe;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready_i;
  logic       frame_start, frame_end, overrun, underrun, abort_f;
  logic       err_clr;

  int n_checks = 0;
  int n_errors = 0;
  int fs_cnt = 0, fe_cnt = 0, rxv_rises = 0;
  logic rxv_prev = 1'b0;

  logic [7:0] tx_q[$];
  logic [7:0] exp_miso[$];
  logic [7:0] exp_rx[$];

  always #5 clk = ~clk;

  spi_target #(
    .SYNC_STAGES (2),
    .DEFAULT_TX  (8'hFF)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .sck_i         (sck),
    .csn_i         (csn),
    .mosi_i        (mosi),
    .miso_o        (miso),
    .miso_oe_o     (miso_oe),
    .tx_data_i     (tx_data_i),
    .tx_valid_i    (tx_valid_i),
    .tx_ready_o    (tx_ready),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (rx_ready_i),
    .frame_start_o (frame_start),
    .frame_end_o   (frame_end),
    .overrun_o     (overrun),
    .underrun_o    (underrun),
    .abort_o       (abort_f),
    .err_clr_i     (err_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // rx consumer side of the scoreboard plus pulse counters.
  always @(negedge clk) begin
    if (rx_valid && rx_ready_i) begin
      if (exp_rx.size() == 0) check_eq("rx_unexpected_byte", exp_rx.size(), 1);
      else                    check_eq("rx_byte", rx_data, exp_rx.pop_front());
    end
    if (rx_valid && !rxv_prev) rxv_rises++;
    rxv_prev = rx_valid;
    if (frame_start) fs_cnt++;
    if (frame_end)   fe_cnt++;
  end

  // tx feeder: presents the next queued byte and advances after each handshake.
  always @(negedge clk) begin
    automatic logic hs = tx_valid_i && tx_ready && rstn;
    @(posedge clk);
    #1;
    if (hs || !tx_valid_i) begin
      if (tx_q.size() > 0) begin
        tx_data_i  = tx_q.pop_front();
        tx_valid_i = 1'b1;
      end else begin
        tx_valid_i = 1'b0;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = mo[i];
      wait_clk(H);
      sck   = 1'b1;
      mi[i] = miso;
      wait_clk(H);
      sck = 1'b0;
    end
  endtask

  task automatic byte_chk(input logic [7:0] mo);
    logic [7:0] mi;
    xfer(mo, 8, mi);
    if (exp_miso.size() == 0) check_eq("miso_unexpected_byte", exp_miso.size(), 1);
    else                      check_eq("miso_byte", mi, exp_miso.pop_front());
  endtask

  task automatic frame_open();
    csn = 1'b0;
    wait_clk(H);
  endtask

  task automatic frame_close();
    wait_clk(H);
    csn = 1'b1;
    wait_clk(2 * H);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    wait_clk(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] mi;
    int fs0, fe0, rv0;
    rstn = 1'b0; sck = 1'b0; csn = 1'b1; mosi = 1'b0;
    tx_data_i = 8'h00; tx_valid_i = 1'b0; rx_ready_i = 1'b1; err_clr = 1'b0;
    wait_clk(4);

    check_eq("rst_tx_ready", tx_ready, 1);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_miso", miso, 0);
    check_eq("rst_miso_oe", miso_oe, 0);
    check_eq("rst_flags", {overrun, underrun, abort_f}, 0);
    check_eq("rst_pulses", {frame_start, frame_end}, 0);
    rstn = 1'b1;
    wait_clk(4);

    // Single byte; trailing 5A keeps the end-of-byte load point fed.
    tx_q.push_back(8'hA5); tx_q.push_back(8'h5A);
    wait_clk(6);
    exp_miso.push_back(8'hA5);
    exp_rx.push_back(8'h3C);
    fs0 = fs_cnt; fe0 = fe_cnt; rv0 = rxv_rises;
    frame_open();
    check_eq("miso_oe_active", miso_oe, 1);
    byte_chk(8'h3C);
    frame_close();
    check_eq("single_fs", fs_cnt - fs0, 1);
    check_eq("single_fe", fe_cnt - fe0, 1);
    check_eq("single_rxv", rxv_rises - rv0, 1);
    check_eq("single_rx_data", rx_data, 8'h3C);
    check_eq("single_flags", {overrun, underrun, abort_f}, 0);
    check_eq("single_rx_left", exp_rx.size(), 0);
    check_eq("idle_miso_oe", miso_oe, 0);

    // Streamed bytes.
    tx_q.push_back(8'h01); tx_q.push_back(8'h02); tx_q.push_back(8'h03); tx_q.push_back(8'h04);
    wait_clk(6);
    exp_miso.push_back(8'h01); exp_miso.push_back(8'h02); exp_miso.push_back(8'h03);
    exp_rx.push_back(8'h10); exp_rx.push_back(8'h20); exp_rx.push_back(8'h30);
    frame_open();
    byte_chk(8'h10);
    byte_chk(8'h20);
    byte_chk(8'h30);
    frame_close();
    check_eq("stream_underrun", underrun, 0);
    check_eq("stream_rx_left", exp_rx.size(), 0);
    check_eq("stream_rx_data", rx_data, 8'h30);

    // Underrun: empty buffer at csn low, 55 arrives mid-byte.
    exp_miso.push_back(8'hFF); exp_miso.push_back(8'h55);
    exp_rx.push_back(8'h11); exp_rx.push_back(8'h22);
    frame_open();
    check_eq("underrun_at_start", underrun, 1);
    fork
      byte_chk(8'h11);
      begin
        wait_clk(6 * H);
        tx_q.push_back(8'h55);
      end
    join
    byte_chk(8'h22);
    frame_close();
    check_eq("underrun_rx_left", exp_rx.size(), 0);
    pulse_err_clr();
    check_eq("underrun_cleared", underrun, 0);

    // Overrun: consumer stalled across two bytes.
    rx_ready_i = 1'b0;
    exp_miso.push_back(8'hFF); exp_miso.push_back(8'hFF);
    rv0 = rxv_rises;
    frame_open();
    byte_chk(8'hAA);
    byte_chk(8'hBB);
    frame_close();
    check_eq("overrun_flag", overrun, 1);
    check_eq("overrun_rx_valid", rx_valid, 1);
    check_eq("overrun_rx_data", rx_data, 8'hBB);
    check_eq("overrun_rxv", rxv_rises - rv0, 1);
    exp_rx.push_back(8'hBB);
    rx_ready_i = 1'b1;
    wait_clk(4);
    check_eq("overrun_drained", rx_valid, 0);
    check_eq("overrun_rx_left", exp_rx.size(), 0);
    pulse_err_clr();
    check_eq("overrun_cleared", overrun, 0);

    // Abort after 5 sck pulses, then a clean frame.
    rv0 = rxv_rises;
    frame_open();
    xfer(8'hF0, 5, mi);
    frame_close();
    check_eq("abort_flag", abort_f, 1);
    check_eq("abort_no_rxv", rxv_rises - rv0, 0);
    check_eq("abort_rx_valid", rx_valid, 0);
    exp_miso.push_back(8'hFF);
    exp_rx.push_back(8'hC3);
    frame_open();
    byte_chk(8'hC3);
    frame_close();
    check_eq("post_abort_rx_data", rx_data, 8'hC3);
    check_eq("post_abort_rx_left", exp_rx.size(), 0);

    // Reset during bit 4 of a frame.
    tx_q.push_back(8'h77);
    wait_clk(6);
    frame_open();
    xfer(8'h96, 3, mi);
    mosi = 1'b1;
    wait_clk(H);
    sck = 1'b1;
    wait_clk(2);
    rstn = 1'b0;
    wait_clk(2);
    check_eq("midrst_tx_ready", tx_ready, 1);
    check_eq("midrst_miso_oe", miso_oe, 0);
    check_eq("midrst_miso", miso, 0);
    check_eq("midrst_rx_valid", rx_valid, 0);
    check_eq("midrst_rx_data", rx_data, 0);
    check_eq("midrst_flags", {overrun, underrun, abort_f}, 0);
    sck = 1'b0; csn = 1'b1;
    wait_clk(4);
    rstn = 1'b1;
    wait_clk(4);
    tx_q.push_back(8'h5A); tx_q.push_back(8'h66);
    wait_clk(6);
    exp_miso.push_back(8'h5A);
    exp_rx.push_back(8'hE7);
    frame_open();
    byte_chk(8'hE7);
    frame_close();
    check_eq("postrst_rx_data", rx_data, 8'hE7);
    check_eq("postrst_flags", {overrun, underrun, abort_f}, 0);
    check_eq("postrst_rx_left", exp_rx.size(), 0);
    check_eq("miso_left", exp_miso.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
